// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial packed-BCD add/subtract unit.
// Processes one digit per clock, least-significant digit first, and ripples
// the decimal carry/borrow from one digit to the next.
// Optional feature: define BCD_INVALID_FLAG_EN to add the invalid_o flag,
// which reports any latched operand digit above 9.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for start_i; result registers hold the last result
//   RUN    | processing digit cnt_q, one digit per clock
//   DONE   | done_o pulse; results valid; a new start_i is accepted here
module bcd_serial_adder #(
  parameter int DIGITS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                sub_i,
  input  logic                carry_in_i,
  input  logic [4*DIGITS-1:0] a_i,
  input  logic [4*DIGITS-1:0] b_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [4*DIGITS-1:0] result_o,
  output logic                carry_out_o,
  output logic                zero_o
`ifdef BCD_INVALID_FLAG_EN
  ,
  output logic                invalid_o
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          sub_q, sub_d;
  logic          c_q, c_d;
  logic [W-1:0]  work_q, work_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          zero_q, zero_d;
`ifdef BCD_INVALID_FLAG_EN
  logic          invalid_q, invalid_d;
  logic          any_bad;
`endif

  logic [3:0]        dig_a, dig_b, dig_nib;
  logic              dig_c;
  logic [4:0]        sum;
  logic signed [5:0] diff;
  logic [W-1:0]      work_nx;

  // Single-digit decimal add/subtract on the digit selected by cnt_q.
  always_comb begin
    dig_a   = a_q[4*int'(cnt_q) +: 4];
    dig_b   = b_q[4*int'(cnt_q) +: 4];
    sum     = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, c_q};
    diff    = $signed({2'b00, dig_a}) - $signed({2'b00, dig_b}) - $signed({5'b00000, ~c_q});
    dig_nib = 4'd0;
    dig_c   = 1'b0;
    if (!sub_q) begin
      if (sum > 5'd9) begin
        dig_nib = sum[3:0] + 4'd6;
        dig_c   = 1'b1;
      end else begin
        dig_nib = sum[3:0];
        dig_c   = 1'b0;
      end
    end else begin
      // borrow is the inverse of the carry (1 = no borrow)
      if (diff < 0) begin
        dig_nib = diff[3:0] + 4'd10;
        dig_c   = 1'b0;
      end else begin
        dig_nib = diff[3:0];
        dig_c   = 1'b1;
      end
    end
    work_nx = work_q;
    work_nx[4*int'(cnt_q) +: 4] = dig_nib;
  end

`ifdef BCD_INVALID_FLAG_EN
  // Flag any latched operand digit outside 0..9.
  always_comb begin
    any_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (a_q[4*k +: 4] > 4'd9 || b_q[4*k +: 4] > 4'd9) any_bad = 1'b1;
    end
  end
`endif

  // Next-state, operand latching and result loading.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    c_d      = c_q;
    work_d   = work_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
`ifdef BCD_INVALID_FLAG_EN
    invalid_d = invalid_q;
`endif
    case (state_q)
      S_RUN: begin
        work_d = work_nx;
        c_d    = dig_c;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = work_nx;
          cout_d   = dig_c;
          zero_d   = (work_nx == '0);
`ifdef BCD_INVALID_FLAG_EN
          invalid_d = any_bad;
`endif
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE falls back to IDLE
        state_d = S_IDLE;
        if (start_i) begin
          state_d = S_RUN;
          cnt_d   = '0;
          a_d     = a_i;
          b_d     = b_i;
          sub_d   = sub_i;
          c_d     = carry_in_i;
          work_d  = '0;
        end
      end
    endcase
  end

  // Control and working registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      c_q     <= c_d;
      work_q  <= work_d;
    end
  end

  // Result registers: only change on the edge that enters DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
`ifdef BCD_INVALID_FLAG_EN
      invalid_q <= 1'b0;
`endif
    end else begin
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
`ifdef BCD_INVALID_FLAG_EN
      invalid_q <= invalid_d;
`endif
    end
  end

  assign busy_o      = (state_q == S_RUN);
  assign done_o      = (state_q == S_DONE);
  assign result_o    = result_q;
  assign carry_out_o = cout_q;
  assign zero_o      = zero_q;
`ifdef BCD_INVALID_FLAG_EN
  assign invalid_o   = invalid_q;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder: one 2-digit and one 4-digit instance
// sharing clock and reset. A decimal integer model predicts each accepted
// operation; a negedge monitor compares handshake and result outputs.
module tb_bcd_serial_adder;

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        zero;
    logic        inv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0] a_s[2];
  logic [15:0] b_s[2];
  logic        sub_s[2];
  logic        cin_s[2];
  logic        start_s[2];

  logic        busy2, done2, cout2, zero2;
  logic [7:0]  res2;
  logic        busy4, done4, cout4, zero4;
  logic [15:0] res4;
`ifdef BCD_INVALID_FLAG_EN
  logic        inv2, inv4;
`endif

  bcd_serial_adder #(.DIGITS(2)) u_dut2 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start_s[0]),
    .sub_i      (sub_s[0]),
    .carry_in_i (cin_s[0]),
    .a_i        (a_s[0][7:0]),
    .b_i        (b_s[0][7:0]),
    .busy_o     (busy2),
    .done_o     (done2),
    .result_o   (res2),
    .carry_out_o(cout2),
    .zero_o     (zero2)
`ifdef BCD_INVALID_FLAG_EN
    ,
    .invalid_o  (inv2)
`endif
  );

  bcd_serial_adder #(.DIGITS(4)) u_dut4 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start_s[1]),
    .sub_i      (sub_s[1]),
    .carry_in_i (cin_s[1]),
    .a_i        (a_s[1]),
    .b_i        (b_s[1]),
    .busy_o     (busy4),
    .done_o     (done4),
    .result_o   (res4),
    .carry_out_o(cout4),
    .zero_o     (zero4)
`ifdef BCD_INVALID_FLAG_EN
    ,
    .invalid_o  (inv4)
`endif
  );

  // ---------------- reference model ----------------
  function automatic longint bcd2int(input logic [15:0] x, input int nd);
    longint v = 0;
    for (int k = nd - 1; k >= 0; k--) v = v * 10 + longint'(x[4*k +: 4]);
    return v;
  endfunction

  function automatic logic [15:0] int2bcd(input longint v, input int nd);
    logic [15:0] r = '0;
    longint t = v;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic c, input int nd);
    exp_t   e;
    longint m = 1;
    longint t;
    for (int k = 0; k < nd; k++) m = m * 10;
    if (!s) begin
      t = bcd2int(a, nd) + bcd2int(b, nd) + (c ? 1 : 0);
      e.cout = (t >= m);
      t = t % m;
    end else begin
      t = bcd2int(a, nd) - bcd2int(b, nd) - (c ? 0 : 1);
      e.cout = (t >= 0);
      if (t < 0) t = t + m;
    end
    e.res  = int2bcd(t, nd);
    e.zero = (t == 0);
    e.inv  = 1'b0;
    for (int k = 0; k < nd; k++)
      if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) e.inv = 1'b1;
    return e;
  endfunction

  function automatic logic [15:0] rand_bcd(input int nd);
    logic [15:0] r = '0;
    for (int k = 0; k < nd; k++) r[4*k +: 4] = 4'($urandom_range(9, 0));
    return r;
  endfunction

  // Model of the handshake: remaining busy edges and pending done per DUT.
  int   m_cnt[2]  = '{0, 0};
  bit   m_done[2] = '{0, 0};
  exp_t q0[$];
  exp_t q1[$];

  // Accept/predict on each rising edge using the bench's own input values.
  always @(posedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_cnt[i]  = 0;
        m_done[i] = 0;
      end else begin
        m_done[i] = (m_cnt[i] == 1);
        if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        else if (start_s[i]) begin
          e = model(a_s[i], b_s[i], sub_s[i], cin_s[i], (i == 0) ? 2 : 4);
          m_cnt[i] = (i == 0) ? 2 : 4;
          if (i == 0) q0.push_back(e);
          else q1.push_back(e);
        end
      end
    end
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end
  end

  // ---------------- monitor ----------------
  int n_chk = 0;
  int n_err = 0;
  logic [15:0] last_res[2];
  logic        last_cout[2];
  logic        last_zero[2];
  logic        last_inv[2];
  bit          end_req = 0;
  bit          end_ack = 0;

  task automatic cmp(input int i, input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL dut%0d %s: actual=%0h required=%0h at %0t", (i == 0) ? 2 : 4, name, act, req, $time);
    end
  endtask

  task automatic check_dut(input int i, input logic [15:0] r, input logic bz, input logic dn,
                           input logic co, input logic zr, input logic iv);
    exp_t e;
    bit   empty;
    cmp(i, "busy", 32'(bz), 32'(m_cnt[i] > 0));
    cmp(i, "done", 32'(dn), 32'(m_done[i]));
    if (!rst_n) begin
      last_res[i]  = '0;
      last_cout[i] = 1'b0;
      last_zero[i] = 1'b0;
      last_inv[i]  = 1'b0;
    end else if (m_done[i]) begin
      empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
      cmp(i, "scoreboard_has_entry", 32'(!empty), 32'd1);
      if (!empty) begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        last_res[i]  = e.res;
        last_cout[i] = e.cout;
        last_zero[i] = e.zero;
        last_inv[i]  = e.inv;
      end
    end
    cmp(i, "result", 32'(r), 32'(last_res[i]));
    cmp(i, "carry_out", 32'(co), 32'(last_cout[i]));
    cmp(i, "zero", 32'(zr), 32'(last_zero[i]));
`ifdef BCD_INVALID_FLAG_EN
    cmp(i, "invalid", 32'(iv), 32'(last_inv[i]));
`else
    if (iv) begin end
`endif
  endtask

  // Compare every DUT output against the scoreboard once per cycle.
  always @(negedge clk) begin
`ifdef BCD_INVALID_FLAG_EN
    check_dut(0, {8'h00, res2}, busy2, done2, cout2, zero2, inv2);
    check_dut(1, res4, busy4, done4, cout4, zero4, inv4);
`else
    check_dut(0, {8'h00, res2}, busy2, done2, cout2, zero2, 1'b0);
    check_dut(1, res4, busy4, done4, cout4, zero4, 1'b0);
`endif
    if (end_req && !end_ack) begin
      cmp(0, "scoreboard_drained", 32'(q0.size()), 32'd0);
      cmp(1, "scoreboard_drained", 32'(q1.size()), 32'd0);
      end_ack = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic op(input int i, input logic [15:0] a, input logic [15:0] b,
                    input logic s, input logic c);
    @(negedge clk);
    a_s[i] = a; b_s[i] = b; sub_s[i] = s; cin_s[i] = c; start_s[i] = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
    a_s[i] = 16'($urandom); b_s[i] = 16'($urandom);
    sub_s[i] = 1'($urandom); cin_s[i] = 1'($urandom);
    repeat (((i == 0) ? 2 : 4) + 1) @(negedge clk);
  endtask

  task automatic rand_stream(input int i, input int held, input int pulsed);
    int nd = (i == 0) ? 2 : 4;
    repeat (held) begin
      @(negedge clk);
      start_s[i] = 1'b1;
      a_s[i] = rand_bcd(nd); b_s[i] = rand_bcd(nd);
      sub_s[i] = 1'($urandom); cin_s[i] = 1'($urandom);
    end
    repeat (pulsed) begin
      @(negedge clk);
      start_s[i] = 1'($urandom);
      a_s[i] = rand_bcd(nd); b_s[i] = rand_bcd(nd);
      sub_s[i] = 1'($urandom); cin_s[i] = 1'($urandom);
    end
    @(negedge clk);
    start_s[i] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_s[i] = '0; b_s[i] = '0; sub_s[i] = 1'b0; cin_s[i] = 1'b0; start_s[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    op(0, 16'h0045, 16'h0038, 1'b0, 1'b0);
    op(0, 16'h0099, 16'h0001, 1'b0, 1'b0);
    op(0, 16'h0000, 16'h0001, 1'b1, 1'b1);
    op(0, 16'h0050, 16'h0025, 1'b1, 1'b1);
    op(0, 16'h0099, 16'h0099, 1'b0, 1'b1);
    op(0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    op(0, 16'h000A, 16'h0000, 1'b0, 1'b0);
    op(0, 16'h0012, 16'h0034, 1'b0, 1'b0);
    op(1, 16'h9999, 16'h0001, 1'b0, 1'b0);
    op(1, 16'h1000, 16'h0001, 1'b1, 1'b1);

    // Abort a 4-digit operation while digit 2 is in flight.
    @(negedge clk);
    a_s[1] = 16'h1234; b_s[1] = 16'h5678; sub_s[1] = 1'b0; cin_s[1] = 1'b1; start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    op(1, 16'h4321, 16'h1234, 1'b1, 1'b1);

    fork
      rand_stream(0, 30, 60);
      rand_stream(1, 30, 60);
    join
    repeat (8) @(negedge clk);

    end_req = 1;
    for (int k = 0; k < 20 && !end_ack; k++) @(negedge clk);
    if (!end_ack) begin
      $display("FAIL end_handshake: actual=0 required=1");
      $fatal(1, "monitor did not finish");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Parametrised decimal (BCD) add/subtract unit for the ALU decimal path. It handles operands of `DIGITS` packed BCD nibbles and processes one digit per clock, least-significant digit first, with a ripple carry/borrow between digits. It uses a start/busy/done handshake and registered results. It replaces the fixed 8-bit single-cycle decimal correction for wide or multi-byte decimal operations.

## Interface
- `DIGITS`, default 2: number of BCD digits per operand; legal range 1–16; operand width W = 4*DIGITS.
- `clk` in 1: clock; all state changes on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request; accepted only on an edge where `busy`=0.
- `sub` in 1: 0 = add, 1 = subtract (a − b).
- `carry_in` in 1: add: carry into digit 0. Sub: 1 = no borrow, 0 = borrow (6502 convention).
- `a` in W: operand A, packed BCD, digit 0 in bits [3:0].
- `b` in W: operand B, packed BCD.
- `busy` out 1: high while digits are being processed.
- `done` out 1: one-cycle pulse; result outputs updated in the same cycle.
- `result` out W: decimal sum/difference.
- `carry_out` out 1: add: decimal carry out of the top digit. Sub: 1 = no borrow, 0 = borrow.
- `zero` out 1: `result`==0.
- `invalid` out 1: present only with `BCD_INVALID_FLAG_EN` (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: `start`=1 → latch `a`, `b`, `sub`, `carry_in`; clear the digit counter; go to RUN.
  - RUN: process digit k = counter. Counter increments each cycle. When k = DIGITS−1 has been processed, go to DONE.
  - DONE: `done`=1 and output registers are loaded. With `start`=1, accept a new operation (same latch actions as IDLE) and go to RUN; otherwise go to IDLE.
- Per-digit add: s = a_k + b_k + c (5 bits).
  - s > 9: nibble = (s+6)[3:0], c = 1.
  - Otherwise: nibble = s[3:0], c = 0.
- Per-digit sub: with borrow = ~c, d = a_k − b_k − borrow (signed).
  - d < 0: nibble = (d+10)[3:0], c = 0.
  - Otherwise: nibble = d[3:0], c = 1.
- Non-BCD input digits (>9) go through the same rules unchanged, with no error correction. Behaviour is deterministic.
- Working result is a shift/indexed register. `result`, `carry_out` and `zero` change only on the edge entering DONE and hold until the next completion.
- `start` while `busy`=1 is ignored; no queueing.
- Operand inputs are don't-care except on the accepting edge.

## Timing
- Reset (async assert): state IDLE, counter 0. `busy`, `done`, `result`, `carry_out`, `zero`, `invalid` all 0. Deassertion is synchronised by the user; the first accept is possible on the first edge after release.
- `start` accepted on edge 0 → `busy`=1 from edge 0 to edge DIGITS.
- Digit k is processed on edge k+1.
- `done`=1 for exactly the cycle after edge DIGITS, with `busy`=0.
- Latency: start to done = DIGITS+1 cycles. Back-to-back throughput: one operation per DIGITS+1 cycles, by re-starting in the DONE cycle.
- `rst_n` asserted mid-RUN aborts the operation. No `done` follows, and outputs return to reset values.
- DIGITS=1: RUN lasts one cycle; `done` appears 2 cycles after the accepting edge.

## Configuration
- `BCD_INVALID_FLAG_EN` defined:
  - `invalid` port exists.
  - It is loaded at DONE with 1 if any latched digit of `a` or `b` exceeds 9, else 0.
  - Held with the other results; reset to 0.
- Not defined: port and detection logic are absent; all other behaviour is identical.

## Test plan
- DIGITS=2, add, a=0x45, b=0x38, carry_in=0 → `result`=0x83, `carry_out`=0, `zero`=0; `done` 3 cycles after accept.
- DIGITS=2, add, a=0x99, b=0x01, carry_in=0 → `result`=0x00, `carry_out`=1, `zero`=1.
- DIGITS=2, sub, a=0x00, b=0x01, carry_in=1 → `result`=0x99, `carry_out`=0. Then a=0x50, b=0x25, carry_in=1 → 0x25, `carry_out`=1.
- DIGITS=2, `start` held high continuously with changing operands → accepts only in IDLE/DONE cycles; `done` every 3 cycles; each result matches the operands latched at its accept. `start` pulses during RUN are ignored.
- DIGITS=4, add 0x9999+0x0001 → 0x0000, `carry_out`=1. Assert `rst_n` low at digit 2 → outputs 0, no `done`; next op completes normally.
- `BCD_INVALID_FLAG_EN`, DIGITS=2, add 0x0A+0x00, carry_in=0 → `result`=0x10, `invalid`=1. Next op 0x12+0x34 → 0x46, `invalid`=0.
